// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// HALT_OPCODE is only acted on when FETCH_HALT_DETECT_EN is defined.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } fetch_state_t;

   localparam logic [5:0] HALT_OPCODE = 6'b111111;
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch stage bus: downstream control, ROM port and IF/ID outputs.
// master = fetch unit, slave = surrounding pipeline/ROM.
interface instr_fetch_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);

   logic                  stall;
   logic                  flush;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_addr;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_data;
   logic                  if_valid;
   logic [DATA_WIDTH-1:0] if_instr;
   logic [ADDR_WIDTH-1:0] if_pc;
   logic [ADDR_WIDTH-1:0] if_pc_next;
   logic                  halted;

   modport master (
      input  stall, flush, redirect_valid, redirect_addr, rom_data,
      output rom_addr, if_valid, if_instr, if_pc, if_pc_next, halted
   );

   modport slave (
      output stall, flush, redirect_valid, redirect_addr, rom_data,
      input  rom_addr, if_valid, if_instr, if_pc, if_pc_next, halted
   );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with redirect/hold/increment next-PC mux.
// Increment wraps silently at 2**ADDR_WIDTH.
module pc_reg #(
   parameter int ADDR_WIDTH = 10,
   parameter int RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic                  hold,
   output logic [ADDR_WIDTH-1:0] pc
);

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] pc_next;

   always_comb begin
      pc_next = pc + ONE;
      if (load) begin
         pc_next = load_addr;
      end else if (hold) begin
         pc_next = pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= ADDR_WIDTH'(RESET_PC);
      end else begin
         pc <= pc_next;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, ROM addressing, IF/ID register and BOOT/RUN/HALT FSM.
// HALT detection is compiled in with FETCH_HALT_DETECT_EN.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int RESET_PC   = 0
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_unit_if.master bus
);

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   fetch_state_t          state;
   fetch_state_t          state_next;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  pc_load;
   logic                  pc_hold;
   logic                  capture;
   logic                  kill;
   logic                  halt_hit;

   logic                  if_valid;
   logic [DATA_WIDTH-1:0] if_instr;
   logic [ADDR_WIDTH-1:0] if_pc;
   logic [ADDR_WIDTH-1:0] if_pc_next;

   pc_reg #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (pc_load),
      .load_addr (bus.redirect_addr),
      .hold      (pc_hold),
      .pc        (pc)
   );

`ifdef FETCH_HALT_DETECT_EN
   assign halt_hit   = bus.rom_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
   assign bus.halted = state == HALT;
`else
   assign halt_hit   = 1'b0;
   assign bus.halted = 1'b0;
`endif

   always_comb begin
      state_next = state;
      pc_load    = 1'b0;
      pc_hold    = 1'b1;
      capture    = 1'b0;
      kill       = 1'b0;
      unique case (state)
         BOOT: begin
            state_next = RUN;
            kill       = 1'b1;
         end
         RUN: begin
            if (bus.redirect_valid) begin
               pc_load = 1'b1;
               kill    = 1'b1;
            end else if (bus.stall) begin
               kill = bus.flush;
            end else begin
               capture = 1'b1;
               pc_hold = 1'b0;
               // HALT word is delivered once, then the PC parks on it
               if (halt_hit && !bus.flush) begin
                  pc_hold    = 1'b1;
                  state_next = HALT;
               end
            end
         end
`ifdef FETCH_HALT_DETECT_EN
         HALT: begin
            kill = 1'b1;
            if (bus.redirect_valid) begin
               pc_load    = 1'b1;
               state_next = RUN;
            end
         end
`endif
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_valid   <= 1'b0;
         if_instr   <= '0;
         if_pc      <= '0;
         if_pc_next <= '0;
      end else if (capture) begin
         if_valid   <= ~bus.flush;
         if_instr   <= bus.rom_data;
         if_pc      <= pc;
         if_pc_next <= pc + ONE;
      end else if (kill) begin
         if_valid <= 1'b0;
      end
   end

   assign bus.rom_addr   = pc;
   assign bus.if_valid   = if_valid;
   assign bus.if_instr   = if_instr;
   assign bus.if_pc      = if_pc;
   assign bus.if_pc_next = if_pc_next;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios then random traffic
// checked against a behavioural fetch model.
module tb_instr_fetch_unit;

   localparam int DW   = 32;
   localparam int AW   = 10;
   localparam int RPC  = 0;
   localparam int SIZE = 1 << AW;

   typedef struct {
      bit          v;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcn;
      bit          h;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   instr_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   instr_fetch_unit #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RESET_PC   (RPC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] rom [0:SIZE-1];
   assign bus.rom_data = rom[bus.rom_addr];

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;

   int   mpc   = 0;
   bit   mboot = 0;
   bit   mhalt = 0;
   bit   known = 0;
   exp_t cur;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model(bit r, bit s, bit f, bit rv, int ra);
      logic [31:0] w;
      if (r) begin
         mpc   = RPC;
         mboot = 1;
         mhalt = 0;
         cur   = '{v: 0, instr: 0, pc: 0, pcn: 0, h: 0};
      end else if (mboot) begin
         mboot = 0;
         cur.v = 0;
      end else if (rv) begin
         mpc   = ra;
         mhalt = 0;
         cur.v = 0;
      end else if (mhalt) begin
         cur.v = 0;
      end else if (s) begin
         if (f) cur.v = 0;
      end else begin
         w         = rom[mpc];
         cur.instr = w;
         cur.pc    = mpc;
         cur.pcn   = (mpc + 1) % SIZE;
         cur.v     = !f;
`ifdef FETCH_HALT_DETECT_EN
         if (!f && w[31:26] == 6'h3F) mhalt = 1;
         else mpc = (mpc + 1) % SIZE;
`else
         mpc = (mpc + 1) % SIZE;
`endif
      end
      cur.h = mhalt;
   endtask

   task automatic cyc(bit r, bit s, bit f, bit rv, int ra);
      @(negedge clk);
      if (known) chk("rom_addr", bus.rom_addr, mpc);
      reset              = r;
      bus.stall          = s;
      bus.flush          = f;
      bus.redirect_valid = rv;
      bus.redirect_addr  = ra[AW-1:0];
      model(r, s, f, rv, ra);
      q.push_back(cur);
      if (r) known = 1;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("if_valid", bus.if_valid, e.v);
         chk("if_instr", bus.if_instr, e.instr);
         chk("if_pc", bus.if_pc, e.pc);
         chk("if_pc_next", bus.if_pc_next, e.pcn);
         chk("halted", bus.halted, e.h);
      end
   end

   initial begin
      logic [31:0] w;
      bus.stall          = 0;
      bus.flush          = 0;
      bus.redirect_valid = 0;
      bus.redirect_addr  = '0;
      for (int i = 0; i < SIZE; i++) begin
         w = $urandom;
         if (w[31:26] == 6'h3F) w[31] = 1'b0;
         rom[i] = w;
      end
      rom[0]   = 32'h11;
      rom[1]   = 32'h22;
      rom[2]   = 32'h33;
      rom[3]   = 32'h44;
      rom[4]   = 32'hFC00_0000;
      rom[100] = 32'hFC00_0123;

      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      run(4);
      repeat (3) cyc(0, 1, 0, 0, 0);
      run(2);
      cyc(0, 1, 0, 1, 'h200);
      run(3);
      cyc(0, 0, 0, 1, 'h5);
      run(2);
      cyc(0, 0, 0, 1, 7);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      run(2);
      cyc(0, 0, 0, 1, 'h3FF);
      run(3);
      cyc(0, 0, 0, 1, 0);
      run(7);
      cyc(0, 0, 0, 1, 0);
      run(3);
      cyc(0, 1, 0, 1, 'h3FE);
      cyc(1, 1, 1, 1, 'h123);
      run(3);

      for (int i = 0; i < 800; i++) begin
         int ra;
         ra = ($urandom % 4 == 0) ? int'($urandom_range(SIZE - 3, SIZE - 1))
                                  : int'($urandom % SIZE);
         if ($urandom % 10 == 0) ra = 98;
         cyc($urandom % 120 == 0, $urandom % 4 == 0, $urandom % 6 == 0,
             $urandom % 9 == 0, ra);
      end
      run(2);

      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
